// File: rtl/fp_operand_swap.sv
// ============================================================================
// Module   : fp_operand_swap
// Purpose  : FP adder operand-ordering stage with a registered valid/ready
//            output and a 2-entry skid buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fp_operand_swap #(
    parameter int FW   = 53,
    parameter int PADW = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               sa,
    input  logic [FW-1:0]      fa,
    input  logic               sb,
    input  logic [FW-1:0]      fb,
    input  logic               eb_gt_ea,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sa2,
    output logic [FW-1:0]      fa2,
    output logic               sb2,
    output logic [FW+PADW-1:0] fb2,
    output logic               swapped
);

    // Word layout: {sign_a, frac_a, sign_b, frac_b_padded, swapped}
    localparam int DW = 1 + FW + 1 + FW + PADW + 1;
    localparam logic [PADW-1:0] C_PAD = '0;

    logic [DW-1:0] w_new_word;
    logic          w_in_fire;
    logic          w_load_out;

    logic [DW-1:0] r_out_word;
    logic          r_out_valid;
    logic [DW-1:0] r_skid_word;
    logic          r_skid_valid;

    always_comb begin
        w_new_word = {sa, fa, sb, fb, C_PAD, 1'b0};
        if (eb_gt_ea) begin
            w_new_word = {sb, fb, sa, fa, C_PAD, 1'b1};
        end
    end

    // in_ready is the inverse of a flop, so it never depends on out_ready
    assign w_in_fire  = in_valid && !r_skid_valid;
    assign w_load_out = !r_out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_word   <= '0;
            r_out_valid  <= 1'b0;
            r_skid_word  <= '0;
            r_skid_valid <= 1'b0;
        end else if (w_load_out) begin
            // Skid entry is older than anything arriving now, so it goes first
            if (r_skid_valid) begin
                r_out_word   <= r_skid_word;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_out_word  <= w_new_word;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid_word  <= w_new_word;
            r_skid_valid <= 1'b1;
        end
    end

    assign in_ready  = !r_skid_valid;
    assign out_valid = r_out_valid;
    assign {sa2, fa2, sb2, fb2, swapped} = r_out_word;

endmodule

`default_nettype wire

// File: tb/tb_fp_operand_swap.sv
// ============================================================================
// Module   : tb_fp_operand_swap
// Purpose  : Randomised self-checking bench for fp_operand_swap against a
//            queue-based reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fp_operand_swap;

    localparam int FW   = 53;
    localparam int PADW = 2;
    localparam int EW   = 1 + FW + 1 + FW + PADW + 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic               sa;
    logic [FW-1:0]      fa;
    logic               sb;
    logic [FW-1:0]      fb;
    logic               eb_gt_ea;
    logic               out_valid;
    logic               out_ready;
    logic               sa2;
    logic [FW-1:0]      fa2;
    logic               sb2;
    logic [FW+PADW-1:0] fb2;
    logic               swapped;

    int n_vec  = 0;
    int n_fail = 0;

    logic [EW-1:0] exp_q[$];

    fp_operand_swap #(.FW(FW), .PADW(PADW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .sa(sa), .fa(fa), .sb(sb), .fb(fb), .eb_gt_ea(eb_gt_ea),
        .out_valid(out_valid), .out_ready(out_ready),
        .sa2(sa2), .fa2(fa2), .sb2(sb2), .fb2(fb2), .swapped(swapped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Larger-exponent operand goes to the a path; smaller fraction gains two zero LSBs
    function automatic logic [EW-1:0] ref_result(input logic s_a, input logic [FW-1:0] f_a,
                                                 input logic s_b, input logic [FW-1:0] f_b,
                                                 input logic x);
        logic               big_s, small_s;
        logic [FW-1:0]      big_f;
        logic [FW+PADW-1:0] small_f;
        big_s   = x ? s_b : s_a;
        big_f   = x ? f_b : f_a;
        small_s = x ? s_a : s_b;
        small_f = (FW+PADW)'(x ? f_a : f_b) << PADW;
        return {big_s, big_f, small_s, small_f, x};
    endfunction

    function automatic logic [FW-1:0] rnd_frac();
        logic [63:0] t;
        int sel;
        sel = $urandom_range(0, 9);
        t = {$urandom, $urandom};
        if (sel == 0) t = '0;
        if (sel == 1) t = '1;
        return t[FW-1:0];
    endfunction

    // Called just after a falling edge: checks outputs, drives inputs, advances one cycle
    task automatic cycle(input logic v, input logic r, input logic s_a, input logic [FW-1:0] f_a,
                         input logic s_b, input logic [FW-1:0] f_b, input logic x);
        logic in_fire, out_fire;
        chk("out_valid", {127'd0, out_valid}, {127'd0, exp_q.size() > 0});
        chk("in_ready", {127'd0, in_ready}, {127'd0, exp_q.size() < 2});
        if (exp_q.size() > 0)
            chk("data", {17'd0, sa2, fa2, sb2, fb2, swapped}, {17'd0, exp_q[0]});
        in_valid  = v;
        out_ready = r;
        sa = s_a; fa = f_a; sb = s_b; fb = f_b; eb_gt_ea = x;
        in_fire  = v && (exp_q.size() < 2);
        out_fire = r && (exp_q.size() > 0);
        @(posedge clk);
        if (out_fire) void'(exp_q.pop_front());
        if (in_fire) exp_q.push_back(ref_result(s_a, f_a, s_b, f_b, x));
        @(negedge clk);
    endtask

    task automatic rnd_cycle(input int p_valid, input int p_ready);
        cycle($urandom_range(0, 99) < p_valid, $urandom_range(0, 99) < p_ready,
              1'($urandom), rnd_frac(), 1'($urandom), rnd_frac(), 1'($urandom));
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_out_valid"}, {127'd0, out_valid}, 128'd0);
        chk({tag, "_in_ready"}, {127'd0, in_ready}, 128'd1);
        chk({tag, "_data"}, {17'd0, sa2, fa2, sb2, fb2, swapped}, 128'd0);
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        sa = 1'b0; fa = '0; sb = 1'b0; fb = '0; eb_gt_ea = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_zero_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed datapath cases
        cycle(1, 1, 1'b1, 53'h1555555555555, 1'b0, 53'h1999999999999, 1'b0);
        chk("noswap_fb2", {73'd0, fb2}, {73'd0, 55'h6666666666664});
        chk("noswap_fa2", {75'd0, fa2}, {75'd0, 53'h1555555555555});
        cycle(1, 1, 1'b0, 53'h1E1E1E1E1E1E0, 1'b1, 53'h0666666666666, 1'b1);
        chk("swap_fa2", {75'd0, fa2}, {75'd0, 53'h0666666666666});
        chk("swap_flag", {127'd0, swapped}, 128'd1);
        cycle(1, 1, 1'b0, '0, 1'b1, '1, 1'b1);
        chk("edge_fa2", {75'd0, fa2}, {75'd0, {FW{1'b1}}});
        chk("edge_fb2", {73'd0, fb2}, 128'd0);
        cycle(0, 1, 1'b0, '0, 1'b0, '0, 1'b0);

        // Backpressure: two pushes while stalled, then drain
        cycle(1, 0, 1'b1, rnd_frac(), 1'b0, rnd_frac(), 1'b0);
        cycle(1, 0, 1'b0, rnd_frac(), 1'b1, rnd_frac(), 1'b1);
        cycle(1, 0, 1'b1, rnd_frac(), 1'b1, rnd_frac(), 1'b0);
        cycle(0, 1, 1'b0, '0, 1'b0, '0, 1'b0);
        cycle(0, 1, 1'b0, '0, 1'b0, '0, 1'b0);
        cycle(0, 1, 1'b0, '0, 1'b0, '0, 1'b0);

        // Streaming with alternating swap
        for (int i = 0; i < 8; i++)
            cycle(1, 1, 1'($urandom), rnd_frac(), 1'($urandom), rnd_frac(), 1'(i % 2));
        cycle(0, 1, 1'b0, '0, 1'b0, '0, 1'b0);

        // Random traffic under varying pressure
        for (int i = 0; i < 300; i++) rnd_cycle(70, 60);
        for (int i = 0; i < 100; i++) rnd_cycle(90, 20);
        for (int i = 0; i < 100; i++) rnd_cycle(30, 90);

        // Asynchronous reset while both entries are held
        cycle(1, 0, 1'b1, rnd_frac(), 1'b1, rnd_frac(), 1'b1);
        cycle(1, 0, 1'b1, rnd_frac(), 1'b0, rnd_frac(), 1'b0);
        chk("stall_full_in_ready", {127'd0, in_ready}, 128'd0);
        #2 rst_n = 1'b0;
        #1 chk_zero_outputs("midreset");
        exp_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) rnd_cycle(60, 60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
